counter_load_sequencer: RTL and testbench

COUNTER_LOAD_SEQUENCER -- requirements
Module: counter_load_sequencer

---
 rtl/counter_load_sequencer.sv | 118 +++++++++++
 tb/tb_counter_load_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/counter_load_sequencer.sv
// Load/enable sequencer for a 74161-style presettable binary counter.
// Periodic (auto-reload) mode exists only when COUNTER_SEQ_RELOAD_EN is defined.
module counter_load_sequencer #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 pause_i,
  input  logic                 auto_reload_i,
  input  logic [WIDTH-1:0]     preset_i,
  input  logic                 ctr_rco_i,
  output logic                 ctr_clear_bar_o,
  output logic                 ctr_load_bar_o,
  output logic                 ctr_enp_o,
  output logic                 ctr_ent_o,
  output logic [WIDTH-1:0]     ctr_d_o,
  output logic                 busy_o,
  output logic                 tick_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] period_count_o
);

  typedef enum logic [2:0] {IDLE, LOAD, COUNT, DONE, ABORT} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     d_q, d_d;
  logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;

`ifdef COUNTER_SEQ_RELOAD_EN
  logic reload_q, reload_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) reload_q <= 1'b0;
    else       reload_q <= reload_d;
  end
`else
  logic unused_auto_reload;
  assign unused_auto_reload = auto_reload_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      d_q     <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    d_d             = d_q;
    pcnt_d          = pcnt_q;
`ifdef COUNTER_SEQ_RELOAD_EN
    reload_d        = reload_q;
`endif
    // Reset also clears the external counter asynchronously.
    ctr_clear_bar_o = ~rst_i;
    ctr_load_bar_o  = 1'b1;
    ctr_enp_o       = 1'b0;
    ctr_ent_o       = 1'b0;
    tick_o          = 1'b0;
    done_o          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          d_d     = preset_i;
          pcnt_d  = '0;
`ifdef COUNTER_SEQ_RELOAD_EN
          reload_d = auto_reload_i;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        ctr_load_bar_o = 1'b0;
        state_d        = abort_i ? ABORT : COUNT;
      end
      COUNT: begin
        ctr_ent_o = 1'b1;
        ctr_enp_o = ~pause_i;
        if (abort_i) begin
          state_d = ABORT;
        end else if (ctr_rco_i && !pause_i) begin
          tick_o = 1'b1;
          if (pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
`ifdef COUNTER_SEQ_RELOAD_EN
          // Reload instead of wrapping so the period is 2^WIDTH - preset.
          if (reload_q) ctr_load_bar_o = 1'b0;
          else          state_d = DONE;
`else
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = abort_i ? ABORT : IDLE;
      end
      ABORT: begin
        ctr_clear_bar_o = 1'b0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o         = (state_q != IDLE);
  assign ctr_d_o        = d_q;
  assign period_count_o = pcnt_q;

endmodule

// File: tb/tb_counter_load_sequencer.sv
// Directed bench: sequencer driving a behavioural 74161 counter model.
module tb_counter_load_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, abort, pause, auto_reload;
  logic [3:0] preset;
  logic       rco, clr_bar, load_bar, enp, ent, busy, tick, done;
  logic [3:0] d, q;
  logic [7:0] pcnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  counter_load_sequencer #(.WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .pause_i(pause),
    .auto_reload_i(auto_reload), .preset_i(preset), .ctr_rco_i(rco),
    .ctr_clear_bar_o(clr_bar), .ctr_load_bar_o(load_bar), .ctr_enp_o(enp),
    .ctr_ent_o(ent), .ctr_d_o(d), .busy_o(busy), .tick_o(tick), .done_o(done),
    .period_count_o(pcnt)
  );

  // 74161: async clear, sync load, count when ENP & ENT.
  always @(posedge clk or negedge clr_bar) begin
    if (!clr_bar)       q <= 4'd0;
    else if (!load_bar) q <= d;
    else if (enp && ent) q <= q + 4'd1;
  end
  assign rco = ent && (q == 4'hF);

  typedef struct {
    logic s, a, p, ar;
    logic [3:0] pre;
    logic [3:0] q, d;
    logic busy, tick, done, ld, clr;
    logic [7:0] pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic a, logic p, logic ar, logic [3:0] pre,
                              logic [3:0] eq, logic [3:0] ed, logic eb, logic et,
                              logic edn, logic eld, logic eclr, logic [7:0] epc);
    vec_t v;
    v.s = s; v.a = a; v.p = p; v.ar = ar; v.pre = pre;
    v.q = eq; v.d = ed; v.busy = eb; v.tick = et; v.done = edn;
    v.ld = eld; v.clr = eclr; v.pc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic s, input logic a, input logic p, input logic ar,
                       input logic [3:0] pre);
    @(negedge clk);
    start = s; abort = a; pause = p; auto_reload = ar; preset = pre;
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; pause = 0; auto_reload = 0; preset = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset q", q, 0);
    chk("reset busy", busy, 0);
    chk("reset clr_bar", clr_bar, 0);
    chk("reset d", d, 0);
    chk("reset pcnt", pcnt, 0);
    chk("reset tick/done", {tick, done}, 0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot Preset=12, with abort-in-idle and start-while-busy ignored.
    vecs.push_back(mk(1,1,0,0,4'd5,  4'd0, 4'd0, 0,0,0,1,1,8'd0));
    vecs.push_back(mk(1,0,0,0,4'd12, 4'd0, 4'd0, 0,0,0,1,1,8'd0));
    vecs.push_back(mk(0,0,0,0,4'd3,  4'd0, 4'd12,1,0,0,0,1,8'd0));
    vecs.push_back(mk(1,0,0,0,4'd3,  4'd12,4'd12,1,0,0,1,1,8'd0));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd13,4'd12,1,0,0,1,1,8'd0));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd14,4'd12,1,0,0,1,1,8'd0));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd15,4'd12,1,1,0,1,1,8'd0));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd0, 4'd12,1,0,1,1,1,8'd1));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd0, 4'd12,0,0,0,1,1,8'd1));
`ifdef COUNTER_SEQ_RELOAD_EN
    // Periodic Preset=13: period 3, then abort.
    vecs.push_back(mk(1,0,0,1,4'd13, 4'd0, 4'd12,0,0,0,1,1,8'd1));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd0, 4'd13,1,0,0,0,1,8'd0));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0,0,0,0,4'd0, 4'd13,4'd13,1,0,0,1,1,8'(k)));
      vecs.push_back(mk(0,0,0,0,4'd0, 4'd14,4'd13,1,0,0,1,1,8'(k)));
      vecs.push_back(mk(0,0,0,0,4'd0, 4'd15,4'd13,1,1,0,0,1,8'(k)));
    end
    vecs.push_back(mk(0,1,0,0,4'd0,  4'd13,4'd13,1,0,0,1,1,8'd3));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd0, 4'd13,1,0,0,1,0,8'd3));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd0, 4'd13,0,0,0,1,1,8'd3));
`else
    // Auto_Reload ignored: Preset=14 runs one-shot.
    vecs.push_back(mk(1,0,0,1,4'd14, 4'd0, 4'd12,0,0,0,1,1,8'd1));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd0, 4'd14,1,0,0,0,1,8'd0));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd14,4'd14,1,0,0,1,1,8'd0));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd15,4'd14,1,1,0,1,1,8'd0));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd0, 4'd14,1,0,1,1,1,8'd1));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd0, 4'd14,0,0,0,1,1,8'd1));
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].a, vecs[i].p, vecs[i].ar, vecs[i].pre);
      chk($sformatf("v%0d q", i),       q,        vecs[i].q);
      chk($sformatf("v%0d d", i),       d,        vecs[i].d);
      chk($sformatf("v%0d busy", i),    busy,     vecs[i].busy);
      chk($sformatf("v%0d tick", i),    tick,     vecs[i].tick);
      chk($sformatf("v%0d done", i),    done,     vecs[i].done);
      chk($sformatf("v%0d load_bar", i), load_bar, vecs[i].ld);
      chk($sformatf("v%0d clr_bar", i), clr_bar,  vecs[i].clr);
      chk($sformatf("v%0d pcnt", i),    pcnt,     vecs[i].pc);
    end

    // Pause held while Q=15: no tick until release.
    drive(1,0,0,0,4'd14);
    drive(0,0,0,0,4'd0);
    drive(0,0,0,0,4'd0);
    chk("pause pre q", q, 14);
    for (int k = 0; k < 5; k++) begin
      drive(0,0,1,0,4'd0);
      chk($sformatf("pause%0d q", k), q, 15);
      chk($sformatf("pause%0d tick", k), tick, 0);
      chk($sformatf("pause%0d enp", k), enp, 0);
    end
    drive(0,0,0,0,4'd0);
    chk("pause release tick", tick, 1);
    drive(0,0,0,0,4'd0);
    chk("pause done", done, 1);
    chk("pause pcnt", pcnt, 1);
    chk("pause q wrap", q, 0);

    // Abort while Q=14.
    drive(1,0,0,0,4'd14);
    drive(0,0,0,0,4'd0);
    drive(0,1,0,0,4'd0);
    chk("abort q14", q, 14);
    chk("abort tick", tick, 0);
    drive(0,0,0,0,4'd0);
    chk("abort clr low", clr_bar, 0);
    chk("abort q cleared", q, 0);
    chk("abort busy", busy, 1);
    chk("abort done", done, 0);
    drive(0,0,0,0,4'd0);
    chk("abort clr released", clr_bar, 1);
    chk("abort busy fell", busy, 0);
    chk("abort pcnt", pcnt, 0);

    // Reset mid-count at Q=9, then a fresh run.
    drive(1,0,0,0,4'd8);
    drive(0,0,0,0,4'd0);
    drive(0,0,0,0,4'd0);
    drive(0,0,0,0,4'd0);
    chk("midrst pre q", q, 9);
    rst = 1'b1;
    #1;
    chk("midrst q", q, 0);
    chk("midrst clr", clr_bar, 0);
    chk("midrst busy", busy, 0);
    chk("midrst d", d, 0);
    chk("midrst pcnt", pcnt, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1,0,0,0,4'd12);
    drive(0,0,0,0,4'd0);
    chk("post-rst load", load_bar, 0);
    chk("post-rst busy", busy, 1);
    drive(0,0,0,0,4'd0);
    chk("post-rst q12", q, 12);
    repeat (3) drive(0,0,0,0,4'd0);
    chk("post-rst tick", tick, 1);
    drive(0,0,0,0,4'd0);
    chk("post-rst done", done, 1);
    chk("post-rst pcnt", pcnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
